// File: rtl/mem_responder.sv
// mem_responder: word-addressed slave for the core's mem_valid/mem_ready fetch port,
// with programmable wait states, a preload port into the array and out-of-range flagging.
//
// state  | meaning
// S_IDLE | waiting for mem_valid
// S_WAIT | counting down wait states while the request is held
// S_RESP | mem_ready high for one cycle with the registered response
module mem_responder #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_valid,
    input  logic [31:0]           mem_addr,
    output logic                  mem_ready,
    output logic [31:0]           mem_rdata,
    output logic                  mem_err,
    input  logic                  ld_we,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic [31:0]           ld_data,
    output logic [15:0]           resp_count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_wait_cnt;
    logic [3:0]            w_wait_cnt_nxt;
    logic                  w_capture;
    logic [31:0]           r_mem [DEPTH];
    logic [31:0]           r_rdata;
    logic                  r_err;
    logic [15:0]           r_resp_count;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_out_of_range;
    logic                  w_unused_addr;

    assign w_idx          = mem_addr[DEPTH_LOG2+1:2];
    assign w_out_of_range = |mem_addr[31:DEPTH_LOG2+2];
    assign w_unused_addr  = ^mem_addr[1:0];

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_capture      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mem_valid) begin
                    if (WAIT_STATES == 0) begin
                        w_state_nxt = S_RESP;
                        w_capture   = 1'b1;
                    end else begin
                        w_state_nxt    = S_WAIT;
                        w_wait_cnt_nxt = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                // A dropped request abandons the transaction silently.
                if (!mem_valid) begin
                    w_state_nxt    = S_IDLE;
                    w_wait_cnt_nxt = 4'd0;
                end else if (r_wait_cnt == 4'd0) begin
                    w_state_nxt = S_RESP;
                    w_capture   = 1'b1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt - 4'd1;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_wait_cnt   <= 4'd0;
            r_rdata      <= 32'd0;
            r_err        <= 1'b0;
            r_resp_count <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_capture) begin
                r_rdata      <= w_out_of_range ? 32'd0 : r_mem[w_idx];
                r_err        <= w_out_of_range;
                r_resp_count <= r_resp_count + 16'd1;
            end
        end
    end

    // Array has no reset so program images survive a core reset.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            r_mem[ld_addr] <= ld_data;
        end
    end

    assign mem_ready  = (r_state == S_RESP);
    assign mem_rdata  = r_rdata;
    assign mem_err    = r_err & mem_ready;
    assign resp_count = r_resp_count;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: three instances (0, 3 and 5 wait states) share the
// clock, address and load port; responses are checked against a queue of expected words.
module tb_mem_responder;
    typedef struct {
        int          inst;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n [3];
    logic        valid [3];
    logic [31:0] addr;
    logic        ready [3];
    logic [31:0] rdata [3];
    logic        err [3];
    logic        ld_we;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data;
    logic [15:0] cnt [3];

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    exp_t sb_q [$];
    exp_t mon_e;
    logic prev_ready [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_responder #(
            .DEPTH_LOG2 (8),
            .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 3 : 5))
        ) u_dut (
            .clk       (clk),
            .rst       (rst_n[g]),
            .mem_valid (valid[g]),
            .mem_addr  (addr),
            .mem_ready (ready[g]),
            .mem_rdata (rdata[g]),
            .mem_err   (err[g]),
            .ld_we     (ld_we),
            .ld_addr   (ld_addr),
            .ld_data   (ld_data),
            .resp_count(cnt[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ws_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 3 : 5);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) prev_ready[i] = 1'b0;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ready[i] === 1'b1) begin
                chk("ready_b2b", 32'(prev_ready[i]), 32'd0);
                if (sb_q.size() == 0) begin
                    chk("stray_ready", 32'(ready[i]), 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("resp_inst", 32'(i), 32'(mon_e.inst));
                    chk("rdata", rdata[i], mon_e.data);
                    chk("err", 32'(err[i]), 32'(mon_e.err));
                    chk("latency", 32'(cyc), 32'(mon_e.cyc));
                end
            end
        end
        for (int i = 0; i < 3; i++) prev_ready[i] = ready[i];
    end

    task automatic load(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_we = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    task automatic push_exp(input int inst, input logic [31:0] d, input logic e, input int c);
        exp_t x;
        x.inst = inst; x.data = d; x.err = e; x.cyc = c;
        sb_q.push_back(x);
    endtask

    task automatic do_req(input int inst, input logic [31:0] a, input logic [31:0] d,
                          input logic e);
        bit got;
        @(negedge clk);
        addr = a;
        valid[inst] = 1'b1;
        push_exp(inst, d, e, cyc + 1 + ws_of(inst));
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            got = (ready[inst] === 1'b1);
        end
        valid[inst] = 1'b0;
        chk("req_done", 32'(got), 32'd1);
    endtask

    localparam logic [31:0] IMG [7] = '{32'h00000001, 32'h10000004, 32'h00000001,
                                        32'h20020000, 32'h22220000, 32'h22440000,
                                        32'h40110000};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        logic [15:0] cnt_before;
        addr = 32'd0; ld_we = 1'b0; ld_addr = 8'd0; ld_data = 32'd0;
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0;
            valid[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_ready", 32'(ready[i]), 32'd0);
            chk("rst_err", 32'(err[i]), 32'd0);
            chk("rst_rdata", rdata[i], 32'd0);
            chk("rst_count", 32'(cnt[i]), 32'd0);
        end
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

        for (int w = 0; w < 7; w++) load(8'(w), IMG[w]);
        load(8'd255, 32'h5A5AA5A5);

        for (int w = 0; w < 7; w++) do_req(0, 32'(w * 4), IMG[w], 1'b0);
        chk("count_seq", 32'(cnt[0]), 32'd7);

        // Held request: one pulse every other cycle.
        @(negedge clk);
        addr = 32'h8;
        valid[0] = 1'b1;
        c = cyc;
        for (int k = 0; k < 5; k++) push_exp(0, 32'h00000001, 1'b0, c + 1 + 2 * k);
        repeat (10) @(negedge clk);
        valid[0] = 1'b0;
        chk("hold_sb_empty", 32'(sb_q.size()), 32'd0);
        chk("count_hold", 32'(cnt[0]), 32'd12);

        do_req(0, 32'h400, 32'd0, 1'b1);
        do_req(0, 32'h3FF, 32'h5A5AA5A5, 1'b0);
        chk("count_range", 32'(cnt[0]), 32'd14);

        do_req(1, 32'hC, 32'h20020000, 1'b0);
        chk("count_ws3", 32'(cnt[1]), 32'd1);
        cnt_before = cnt[1];
        @(negedge clk);
        addr = 32'hC;
        valid[1] = 1'b1;
        repeat (2) @(negedge clk);
        valid[1] = 1'b0;
        repeat (10) @(negedge clk);
        chk("count_violation", 32'(cnt[1]), 32'(cnt_before));

        do_req(2, 32'h10, 32'h22220000, 1'b0);
        chk("count_ws5", 32'(cnt[2]), 32'd1);
        @(negedge clk);
        addr = 32'h4;
        valid[2] = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        rst_n[2] = 1'b0;
        valid[2] = 1'b0;
        #1;
        chk("async_rst_ready", 32'(ready[2]), 32'd0);
        chk("async_rst_err", 32'(err[2]), 32'd0);
        chk("async_rst_count", 32'(cnt[2]), 32'd0);
        chk("async_rst_rdata", rdata[2], 32'd0);
        @(negedge clk);
        rst_n[2] = 1'b1;
        repeat (15) @(negedge clk);
        do_req(2, 32'h4, 32'h10000004, 1'b0);
        chk("count_after_rst", 32'(cnt[2]), 32'd1);

        // Load and response capture on the same word and edge.
        @(negedge clk);
        addr = 32'hC;
        valid[0] = 1'b1;
        ld_we = 1'b1; ld_addr = 8'd3; ld_data = 32'hDEADBEEF;
        push_exp(0, 32'h20020000, 1'b0, cyc + 1);
        @(negedge clk);
        ld_we = 1'b0;
        valid[0] = 1'b0;
        chk("coll_ready", 32'(ready[0]), 32'd1);
        do_req(0, 32'hC, 32'hDEADBEEF, 1'b0);
        chk("count_coll", 32'(cnt[0]), 32'd16);

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
